// File: rtl/uart_proto_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_proto_pkg
// Description : Shared UART command/response protocol constants. Function
//               codes, frame delimiters, packer state encoding and the
//               response-length lookup used by the packer and the receive-side
//               mapper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_proto_pkg;

    typedef logic [7:0] octet_t;

    // Request function codes
    localparam octet_t FUNC_HS_RD = 8'h01;
    localparam octet_t FUNC_LS_RD = 8'h02;

    // Response function codes
    localparam octet_t RFUNC_HS  = 8'h81;
    localparam octet_t RFUNC_LS  = 8'h82;
    localparam octet_t RFUNC_ERR = 8'hFF;

    // Frame delimiters
    localparam octet_t DEF_HEADER = 8'hAA;
    localparam octet_t DEF_TAIL   = 8'h55;

    // Frame geometry: HEADER RFUNC CH LEN payload CHK TAIL
    localparam int unsigned FRAME_BUF_BYTES = 14;
    localparam int unsigned TAIL_SLOT       = FRAME_BUF_BYTES - 1;
    localparam logic [3:0]  PAYLOAD_OFS     = 4'd4;
    localparam logic [3:0]  FRAME_OVERHEAD  = 4'd6;

    // Lost-busy guard: last WAIT_HI cycle count before giving up on tx_busy
    localparam logic [2:0]  GUARD_LAST = 3'd7;

    // Packer state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEL     = 3'd1;
    localparam logic [2:0] ST_LATCH   = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_HI = 3'd4;
    localparam logic [2:0] ST_WAIT_LO = 3'd5;

    // Payload length carried by a response of the given function code
    function automatic logic [3:0] resp_len(input octet_t rfunc);
        case (rfunc)
            RFUNC_HS: return 4'd9;
            RFUNC_LS: return 4'd1;
            default:  return 4'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_chk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_frame_chk
// Description : 8-bit wrap-around byte accumulator producing the frame CHK.
//               clr_i has priority over add_en_i.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       add_en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] chk_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    // Next running sum: clear, accumulate or hold
    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (add_en_i) begin
            sum_d = sum_q + byte_i;
        end
    end

    // Running sum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chk_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/uart_resp_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_resp_packer
// Description : Builds HS/LS readback response frames from the register bank
//               and streams them byte by byte to a UART transmitter with
//               tx_en / tx_busy handshaking and a lost-busy guard.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_resp_packer
    import uart_proto_pkg::*;
#(
    parameter int unsigned _NUM_CHANNELS = 4,
    parameter logic [7:0]  HEADER        = DEF_HEADER,
    parameter logic [7:0]  TAIL          = DEF_TAIL
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [7:0]  req_func,
    input  logic [7:0]  req_ch,
    output logic [7:0]  rd_ch,
    input  logic [7:0]  rd_hs_ctrl_sta,
    input  logic [7:0]  rd_duty_num,
    input  logic [15:0] rd_pulse_dessert,
    input  logic [7:0]  rd_pulse_num,
    input  logic [31:0] rd_PAT,
    input  logic [7:0]  rd_ls_ctrl_sta,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_busy,
    output logic        busy,
    output logic        req_drop
);

    logic [2:0] state_q,   state_d;
    octet_t     func_q,    func_d;
    octet_t     ch_q,      ch_d;
    octet_t     frame_q [FRAME_BUF_BYTES];
    octet_t     frame_d [FRAME_BUF_BYTES];
    logic [3:0] len_q,     len_d;
    logic [3:0] cnt_q,     cnt_d;
    logic [3:0] idx_q,     idx_d;
    logic [2:0] guard_q,   guard_d;
    octet_t     tx_data_q, tx_data_d;
    logic       tx_en_q,   tx_en_d;
    logic       busy_q,    busy_d;
    logic       drop_q,    drop_d;

    logic       w_ch_ok;
    octet_t     w_rfunc;
    logic [3:0] w_len;
    octet_t     w_byte;
    octet_t     w_chk;
    logic       w_chk_clr;
    logic       w_chk_add;
    logic       w_last;

    assign w_ch_ok = ({24'd0, ch_q} < _NUM_CHANNELS);

    // Response code of the captured request; bad func or channel -> error frame
    always_comb begin
        w_rfunc = RFUNC_ERR;
        if (w_ch_ok && func_q == FUNC_HS_RD) begin
            w_rfunc = RFUNC_HS;
        end else if (w_ch_ok && func_q == FUNC_LS_RD) begin
            w_rfunc = RFUNC_LS;
        end
    end

    assign w_len  = resp_len(w_rfunc);
    assign w_last = (idx_q == cnt_q - 4'd1);

    // Outgoing byte: buffered header/body, then running CHK, then buffered TAIL
    always_comb begin
        w_byte = frame_q[TAIL_SLOT];
        if (idx_q < PAYLOAD_OFS + len_q) begin
            w_byte = frame_q[idx_q];
        end else if (idx_q == PAYLOAD_OFS + len_q) begin
            w_byte = w_chk;
        end
    end

    // CHK covers RFUNC..last payload byte, accumulated as those bytes go out
    assign w_chk_clr = (state_q == ST_LATCH);
    assign w_chk_add = (state_q == ST_SEND) && !tx_busy &&
                       (idx_q != 4'd0) && (idx_q < PAYLOAD_OFS + len_q);

    uart_frame_chk u_chk (
        .clk      (clk_50M),
        .rst_n    (rst_n),
        .clr_i    (w_chk_clr),
        .add_en_i (w_chk_add),
        .byte_i   (w_byte),
        .chk_o    (w_chk)
    );

    // Frame sequencer next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        ch_d      = ch_q;
        frame_d   = frame_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        guard_d   = guard_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        busy_d    = busy_q;
        // Includes the cycle busy falls, since busy_q is still high there
        drop_d    = req_valid && busy_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    func_d  = req_func;
                    ch_d    = req_ch;
                    busy_d  = 1'b1;
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                // rd_ch settles this cycle; mux data is valid in LATCH
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                for (int i = 0; i < FRAME_BUF_BYTES; i++) begin
                    frame_d[i] = 8'h00;
                end
                frame_d[0] = HEADER;
                frame_d[1] = w_rfunc;
                frame_d[2] = ch_q;
                frame_d[3] = {4'd0, w_len};
                if (w_rfunc == RFUNC_HS) begin
                    frame_d[4]  = rd_hs_ctrl_sta;
                    frame_d[5]  = rd_duty_num;
                    frame_d[6]  = rd_pulse_dessert[15:8];
                    frame_d[7]  = rd_pulse_dessert[7:0];
                    frame_d[8]  = rd_pulse_num;
                    frame_d[9]  = rd_PAT[31:24];
                    frame_d[10] = rd_PAT[23:16];
                    frame_d[11] = rd_PAT[15:8];
                    frame_d[12] = rd_PAT[7:0];
                end else if (w_rfunc == RFUNC_LS) begin
                    frame_d[4]  = rd_ls_ctrl_sta;
                end
                frame_d[TAIL_SLOT] = TAIL;
                len_d   = w_len;
                cnt_d   = FRAME_OVERHEAD + w_len;
                idx_d   = 4'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_data_d = w_byte;
                    tx_en_d   = 1'b1;
                    guard_d   = 3'd0;
                    state_d   = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy || guard_q == GUARD_LAST) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    guard_d = guard_q + 3'd1;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (w_last) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            func_q    <= 8'h00;
            ch_q      <= 8'h00;
            frame_q   <= '{default: 8'h00};
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            idx_q     <= 4'd0;
            guard_q   <= 3'd0;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            ch_q      <= ch_d;
            frame_q   <= frame_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            guard_q   <= guard_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign rd_ch    = ch_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;
    assign req_drop = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_resp_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_resp_packer
// Description : Self-checking bench for uart_resp_packer: register-bank mux
//               model, UART transmitter model and a frame reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_resp_packer;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [7:0]  req_func;
    logic [7:0]  req_ch;
    logic [7:0]  rd_ch;
    logic [7:0]  rd_hs_ctrl_sta;
    logic [7:0]  rd_duty_num;
    logic [15:0] rd_pulse_dessert;
    logic [7:0]  rd_pulse_num;
    logic [31:0] rd_PAT;
    logic [7:0]  rd_ls_ctrl_sta;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic        req_drop;

    int n_vec = 0;
    int n_err = 0;

    // Register bank contents, one entry per channel index (low 3 bits)
    logic [7:0]  bank_hs   [8];
    logic [7:0]  bank_duty [8];
    logic [15:0] bank_dess [8];
    logic [7:0]  bank_num  [8];
    logic [31:0] bank_pat  [8];
    logic [7:0]  bank_ls   [8];

    // UART / monitor state
    int          uart_mode = 1;   // 0: tx_busy never rises, 1: random busy time
    int          busy_cnt  = 0;
    int          cyc       = 0;
    logic [7:0]  rx_q[$];
    int          en_stamp[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  hold_val  = 8'h00;
    bit          have_val  = 1'b0;
    bit          prev_en   = 1'b0;
    int          stab_err  = 0;
    int          dbl_err   = 0;
    int          drop_cnt  = 0;

    always #5 clk = ~clk;

    uart_resp_packer dut (
        .clk_50M          (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_func         (req_func),
        .req_ch           (req_ch),
        .rd_ch            (rd_ch),
        .rd_hs_ctrl_sta   (rd_hs_ctrl_sta),
        .rd_duty_num      (rd_duty_num),
        .rd_pulse_dessert (rd_pulse_dessert),
        .rd_pulse_num     (rd_pulse_num),
        .rd_PAT           (rd_PAT),
        .rd_ls_ctrl_sta   (rd_ls_ctrl_sta),
        .tx_data          (tx_data),
        .tx_en            (tx_en),
        .tx_busy          (tx_busy),
        .busy             (busy),
        .req_drop         (req_drop)
    );

    // Registered read mux: data valid one cycle after rd_ch changes
    always @(posedge clk) begin
        rd_hs_ctrl_sta   <= bank_hs[rd_ch[2:0]];
        rd_duty_num      <= bank_duty[rd_ch[2:0]];
        rd_pulse_dessert <= bank_dess[rd_ch[2:0]];
        rd_pulse_num     <= bank_num[rd_ch[2:0]];
        rd_PAT           <= bank_pat[rd_ch[2:0]];
        rd_ls_ctrl_sta   <= bank_ls[rd_ch[2:0]];
    end

    // UART transmitter model plus handshake monitors
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_en === 1'b1) begin
            rx_q.push_back(tx_data);
            en_stamp.push_back(cyc);
            if (prev_en) dbl_err = dbl_err + 1;
            hold_val = tx_data;
            have_val = 1'b1;
            busy_cnt = (uart_mode != 0) ? int'($urandom_range(12, 1)) : 0;
        end else begin
            if (!rst_n) have_val = 1'b0;
            else if (have_val && tx_data !== hold_val) stab_err = stab_err + 1;
            if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        end
        prev_en = (tx_en === 1'b1);
        if (req_drop === 1'b1) drop_cnt = drop_cnt + 1;
        tx_busy <= (busy_cnt > 0);
    end

    // Reference frame from the bank contents at request time
    task automatic build_expected(input logic [7:0] f, input logic [7:0] c);
        logic [7:0] pl[$];
        logic [7:0] rf;
        int         ci;
        int         sum;
        ci = int'(c[2:0]);
        pl.delete();
        if (f == 8'h01 && int'(c) < NCH) begin
            rf = 8'h81;
            pl.push_back(bank_hs[ci]);
            pl.push_back(bank_duty[ci]);
            pl.push_back(bank_dess[ci][15:8]);
            pl.push_back(bank_dess[ci][7:0]);
            pl.push_back(bank_num[ci]);
            pl.push_back(bank_pat[ci][31:24]);
            pl.push_back(bank_pat[ci][23:16]);
            pl.push_back(bank_pat[ci][15:8]);
            pl.push_back(bank_pat[ci][7:0]);
        end else if (f == 8'h02 && int'(c) < NCH) begin
            rf = 8'h82;
            pl.push_back(bank_ls[ci]);
        end else begin
            rf = 8'hFF;
        end
        sum = int'(rf) + int'(c) + pl.size();
        foreach (pl[i]) sum = sum + int'(pl[i]);
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(rf);
        exp_q.push_back(c);
        exp_q.push_back(8'(pl.size()));
        foreach (pl[i]) exp_q.push_back(pl[i]);
        exp_q.push_back(8'(sum));
        exp_q.push_back(8'h55);
    endtask

    task automatic randomize_bank();
        for (int i = 0; i < 8; i++) begin
            bank_hs[i]   = 8'($urandom);
            bank_duty[i] = 8'($urandom);
            bank_dess[i] = 16'($urandom);
            bank_num[i]  = 8'($urandom);
            bank_pat[i]  = $urandom;
            bank_ls[i]   = 8'($urandom);
        end
    endtask

    task automatic send_req(input logic [7:0] f, input logic [7:0] c);
        @(negedge clk);
        req_valid = 1'b1;
        req_func  = f;
        req_ch    = c;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int k;
        k = 0;
        timed_out = 1'b0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) timed_out = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] f, input logic [7:0] c, output bit timed_out);
        rx_q.delete();
        en_stamp.delete();
        build_expected(f, c);
        send_req(f, c);
        wait_idle(timed_out);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_func  = 8'h00;
        req_ch    = 8'h00;
        repeat (3) @(negedge clk);
        n_vec++; if (tx_en !== 1'b0)     begin n_err++; $display("FAIL reset tx_en: got %b want 0", tx_en); end
        n_vec++; if (tx_data !== 8'h00)  begin n_err++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
        n_vec++; if (rd_ch !== 8'h00)    begin n_err++; $display("FAIL reset rd_ch: got %h want 00", rd_ch); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL reset busy: got %b want 0", busy); end
        n_vec++; if (req_drop !== 1'b0)  begin n_err++; $display("FAIL reset req_drop: got %b want 0", req_drop); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ls_vector();
        logic [7:0] v [7];
        bit to;
        v = '{8'hAA, 8'h82, 8'h01, 8'h01, 8'h3C, 8'hC0, 8'h55};
        uart_mode = 1;
        bank_ls[1] = 8'h3C;
        rx_q.delete();
        send_req(8'h02, 8'h01);
        n_vec++; if (busy !== 1'b1)   begin n_err++; $display("FAIL accept busy: got %b want 1", busy); end
        n_vec++; if (rd_ch !== 8'h01) begin n_err++; $display("FAIL accept rd_ch: got %h want 01", rd_ch); end
        wait_idle(to);
        n_vec++;
        if (to || rx_q.size() != 7) begin
            n_err++; $display("FAIL ls_vector length: got %0d want 7 (timeout=%0b)", rx_q.size(), to);
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_vec++;
                if (rx_q[i] !== v[i]) begin n_err++; $display("FAIL ls_vector byte%0d: got %h want %h", i, rx_q[i], v[i]); end
            end
        end
    endtask

    task automatic test_hs_vector();
        logic [7:0] v [15];
        bit to;
        v = '{8'hAA, 8'h81, 8'h00, 8'h09, 8'h01, 8'h10, 8'h00, 8'h20,
              8'h03, 8'hA5, 8'hA5, 8'h00, 8'h01, 8'h09, 8'h55};
        bank_hs[0] = 8'h01; bank_duty[0] = 8'h10; bank_dess[0] = 16'h0020;
        bank_num[0] = 8'h03; bank_pat[0] = 32'hA5A50001;
        rx_q.delete();
        send_req(8'h01, 8'h00);
        wait_idle(to);
        n_vec++;
        if (to || rx_q.size() != 15) begin
            n_err++; $display("FAIL hs_vector length: got %0d want 15 (timeout=%0b)", rx_q.size(), to);
        end else begin
            for (int i = 0; i < 15; i++) begin
                n_vec++;
                if (rx_q[i] !== v[i]) begin n_err++; $display("FAIL hs_vector byte%0d: got %h want %h", i, rx_q[i], v[i]); end
            end
        end
    endtask

    task automatic test_err_vector();
        logic [7:0] v [6];
        bit to;
        v = '{8'hAA, 8'hFF, 8'h05, 8'h00, 8'h04, 8'h55};
        rx_q.delete();
        send_req(8'h01, 8'h05);
        wait_idle(to);
        n_vec++;
        if (to || rx_q.size() != 6) begin
            n_err++; $display("FAIL err_vector length: got %0d want 6 (timeout=%0b)", rx_q.size(), to);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_vec++;
                if (rx_q[i] !== v[i]) begin n_err++; $display("FAIL err_vector byte%0d: got %h want %h", i, rx_q[i], v[i]); end
            end
        end
    endtask

    task automatic test_random();
        bit to;
        logic [7:0] f;
        logic [7:0] c;
        int r;
        uart_mode = 1;
        for (int n = 0; n < 16; n++) begin
            randomize_bank();
            r = int'($urandom_range(9, 0));
            f = (r < 4) ? 8'h01 : (r < 7) ? 8'h02 : (r == 7) ? 8'h03 : 8'($urandom);
            c = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'($urandom_range(5, 0));
            do_frame(f, c, to);
            n_vec++;
            if (to || rx_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL random[%0d] f=%h c=%h length: got %0d want %0d", n, f, c, rx_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_vec++;
                    if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL random[%0d] byte%0d: got %h want %h", n, i, rx_q[i], exp_q[i]); end
                end
            end
        end
    endtask

    task automatic test_back_to_back_drop();
        bit to;
        uart_mode = 1;
        randomize_bank();
        rx_q.delete();
        build_expected(8'h01, 8'h02);
        drop_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; req_func = 8'h01; req_ch = 8'h02;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        req_valid = 1'b1; req_func = 8'h02; req_ch = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle(to);
        n_vec++; if (drop_cnt != 1) begin n_err++; $display("FAIL drop count: got %0d want 1", drop_cnt); end
        n_vec++;
        if (to || rx_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL drop frame length: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL drop frame byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_lost_busy_guard();
        bit to;
        int k;
        uart_mode = 0;
        randomize_bank();
        do_frame(8'h01, 8'h02, to);
        n_vec++;
        if (to || rx_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL guard frame length: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL guard byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
            // SEND + 8 guard cycles + WAIT_LO between successive starts
            for (int i = 1; i < en_stamp.size(); i++) begin
                n_vec++;
                if (en_stamp[i] - en_stamp[i-1] != 10) begin
                    n_err++; $display("FAIL guard spacing%0d: got %0d want 10", i, en_stamp[i] - en_stamp[i-1]);
                end
            end
        end
        // A request landing in the cycle busy falls must be dropped
        rx_q.delete();
        drop_cnt = 0;
        send_req(8'h02, 8'h03);
        k = 0;
        while (rx_q.size() < 7 && k < 500) begin @(negedge clk); k++; end
        n_vec++;
        if (k >= 500) begin
            n_err++; $display("FAIL fall_drop wait: got %0d bytes want 7", rx_q.size());
        end else begin
            repeat (7) @(negedge clk);
            req_valid = 1'b1; req_func = 8'h01; req_ch = 8'h00;
            @(negedge clk);
            req_valid = 1'b0;
            n_vec++; if (req_drop !== 1'b1) begin n_err++; $display("FAIL fall_drop req_drop: got %b want 1", req_drop); end
            n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL fall_drop busy: got %b want 0", busy); end
            repeat (20) @(negedge clk);
            n_vec++; if (rx_q.size() != 7)  begin n_err++; $display("FAIL fall_drop extra bytes: got %0d want 7", rx_q.size()); end
            n_vec++; if (drop_cnt != 1)     begin n_err++; $display("FAIL fall_drop count: got %0d want 1", drop_cnt); end
        end
        uart_mode = 1;
    endtask

    task automatic test_capture_freeze();
        bit to;
        int k;
        uart_mode = 1;
        randomize_bank();
        rx_q.delete();
        build_expected(8'h01, 8'h01);
        send_req(8'h01, 8'h01);
        k = 0;
        while (rx_q.size() < 2 && k < 500) begin @(negedge clk); k++; end
        randomize_bank();
        wait_idle(to);
        n_vec++;
        if (to || rx_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL freeze length: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL freeze byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        int k;
        uart_mode = 1;
        randomize_bank();
        rx_q.delete();
        send_req(8'h01, 8'h03);
        k = 0;
        while (rx_q.size() < 4 && k < 500) begin @(negedge clk); k++; end
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (tx_en !== 1'b0) begin n_err++; $display("FAIL midreset tx_en: got %b want 0", tx_en); end
            n_vec++; if (busy !== 1'b0)  begin n_err++; $display("FAIL midreset busy: got %b want 0", busy); end
        end
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_vec++; if (rx_q.size() != 4) begin n_err++; $display("FAIL midreset bytes: got %0d want 4", rx_q.size()); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL midreset idle busy: got %b want 0", busy); end
        do_frame(8'h01, 8'h00, to);
        n_vec++;
        if (to || rx_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL postreset length: got %0d want %0d", rx_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL postreset byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_handshake();
        n_vec++; if (stab_err != 0) begin n_err++; $display("FAIL tx_data hold: got %0d changes want 0", stab_err); end
        n_vec++; if (dbl_err != 0)  begin n_err++; $display("FAIL tx_en width: got %0d long pulses want 0", dbl_err); end
    endtask

    initial begin
        randomize_bank();
        test_reset();
        test_ls_vector();
        test_hs_vector();
        test_err_vector();
        test_random();
        test_back_to_back_drop();
        test_lost_busy_guard();
        test_capture_freeze();
        test_reset_midframe();
        test_handshake();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
